// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives imem via req/ready, delivers to IF/ID.
// Handles hazard freeze (hold buffer) and EXE redirects, including redirects mid-access.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instruction,
  output logic              imem_timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [DATA_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0]   hold_instr_q, hold_instr_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    wait_cnt_d   = '0;
    timeout_d    = timeout_q;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (branch_taken) begin
          pc_d       = branch_address;
          if_valid_d = 1'b0;
          state_d    = imem_ready ? FETCH : DRAIN;
        end else if (imem_ready) begin
          pc_d = pc_q + ADDR_W'(4);
          if (freeze) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
          end
        end else if (!freeze) begin
          if_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        // The stale access must complete before the redirected fetch can be issued
        if (branch_taken) begin
          pc_d       = branch_address;
          if_valid_d = 1'b0;
        end
        if (imem_ready) state_d = FETCH;
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d         = branch_address;
          if_valid_d   = 1'b0;
          hold_pc_d    = '0;
          hold_instr_d = '0;
          state_d      = FETCH;
        end else if (!freeze) begin
          if_valid_d = 1'b1;
          if_pc_d    = hold_pc_q;
          if_instr_d = hold_instr_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == FETCH || state_q == DRAIN) && !imem_ready)
      wait_cnt_d = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    if (wait_cnt_d == CNT_W'(MAX_WAIT)) timeout_d = 1'b1;

    req_d  = (state_d == FETCH) || (state_d == DRAIN);
    addr_d = (state_d == FETCH) ? pc_d : addr_q;
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign pc             = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign imem_timeout   = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; imem data is a fixed tag plus the low address bits.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ready;
  logic [31:0] branch_address, imem_addr, imem_rdata, pc, if_pc, if_instruction;
  logic        imem_req, if_valid, imem_timeout;
  int          total = 0;
  int          bad   = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .if_valid(if_valid),
    .if_pc(if_pc), .if_instruction(if_instruction), .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    branch_address = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    // reset state
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0; branch_address = '0;
    step(); step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_ifpc", if_pc, 32'd0);
    check("rst_instr", if_instruction, 32'd0);
    check("rst_tmo", 32'(imem_timeout), 32'd0);
    rst = 1'b0;
    step();
    check("idle2fetch_req", 32'(imem_req), 32'd1);
    check("idle2fetch_addr", imem_addr, 32'd0);

    // zero-wait memory: one instruction per cycle
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("zw_valid", 32'(if_valid), 32'd1);
      check("zw_ifpc", if_pc, 32'(4 * i));
      check("zw_instr", if_instruction, 32'hC0DE0000 | 32'(4 * i));
      check("zw_addr", imem_addr, 32'(4 * i + 4));
    end

    // ready returns on the third cycle of each access
    do_reset();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
        step();
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr", imem_addr, 32'(4 * i));
        check("wait_valid", 32'(if_valid), 32'd0);
      end
      imem_ready = 1'b1;
      step();
      check("slow_valid", 32'(if_valid), 32'd1);
      check("slow_ifpc", if_pc, 32'(4 * i));
    end

    // freeze when the access for pc=8 completes
    do_reset();
    imem_ready = 1'b1;
    step(); step();
    freeze = 1'b1;
    step();
    check("hold_req", 32'(imem_req), 32'd0);
    check("hold_ifpc", if_pc, 32'd4);
    check("hold_valid", 32'(if_valid), 32'd1);
    check("hold_pc", pc, 32'd12);
    imem_ready = 1'b0;
    step();
    check("hold2_req", 32'(imem_req), 32'd0);
    check("hold2_ifpc", if_pc, 32'd4);
    freeze = 1'b0;
    step();
    check("unhold_valid", 32'(if_valid), 32'd1);
    check("unhold_ifpc", if_pc, 32'd8);
    check("unhold_instr", if_instruction, 32'hC0DE0008);
    check("unhold_req", 32'(imem_req), 32'd1);
    check("unhold_addr", imem_addr, 32'd12);
    imem_ready = 1'b1;
    step();
    check("after_hold_ifpc", if_pc, 32'd12);

    // redirect while the access at 0x10 is waiting
    do_reset();
    imem_ready = 1'b1;
    repeat (4) step();
    check("pre_br_addr", imem_addr, 32'h10);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_address = 32'h100;
    step();
    branch_taken = 1'b0;
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_addr", imem_addr, 32'h10);
    check("drain_valid", 32'(if_valid), 32'd0);
    check("drain_pc", pc, 32'h100);
    step();
    check("drain2_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    step();
    check("drop_valid", 32'(if_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    step();
    check("redir_ifpc", if_pc, 32'h100);
    check("redir_instr", if_instruction, 32'hC0DE0100);

    // branch, freeze and ready together: flush, no HOLD; then pc wrap
    do_reset();
    imem_ready = 1'b1;
    step();
    branch_taken = 1'b1; freeze = 1'b1; branch_address = 32'h200;
    step();
    branch_taken = 1'b0; freeze = 1'b0;
    check("bfr_pc", pc, 32'h200);
    check("bfr_valid", 32'(if_valid), 32'd0);
    check("bfr_req", 32'(imem_req), 32'd1);
    check("bfr_addr", imem_addr, 32'h200);
    step();
    check("bfr_ifpc", if_pc, 32'h200);
    branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step();
    check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'd0);
    check("wrap_pc", pc, 32'd0);

    // watchdog with imem_ready tied low, then reset mid-DRAIN
    do_reset();
    repeat (14) step();
    check("tmo_early", 32'(imem_timeout), 32'd0);
    step();
    check("tmo_set", 32'(imem_timeout), 32'd1);
    branch_taken = 1'b1; branch_address = 32'h40;
    step();
    branch_taken = 1'b0;
    repeat (3) step();
    check("tmo_sticky", 32'(imem_timeout), 32'd1);
    check("tmo_drain_addr", imem_addr, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_drain_req", 32'(imem_req), 32'd0);
    check("rst_drain_tmo", 32'(imem_timeout), 32'd0);
    check("rst_drain_pc", pc, 32'd0);
    step();
    check("rst_drain_refetch", 32'(imem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
